rf_shadow_checker: RTL and testbench
====================================

RF_SHADOW_CHECKER -- requirements
Module: rf_shadow_checker

Interface
REQ-001 The block SHALL have these parameters: XLEN, default 32, data width; DEPTH, default 32, register count; RD_PORTS, default 2, number of read ports checked; BYPASS, default 0, where 1 means a same-cycle write is visible on reads; CNT_W, default 16, counter width.
REQ-002 The derived width AW SHALL be $clog2(DEPTH); register 0 SHALL be the hardwired-zero register.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- chk_en  in  1  enables read checking
- err_clr  in  1  clears error capture and counters
- wr_en  in  1  DUT write enable
- wr_reg  in  AW  DUT write address
- wr_data  in  XLEN  DUT write data
- rd_reg  in  RD_PORTS*AW  read addresses; port i at [i*AW +: AW]
- rd_data  in  RD_PORTS*XLEN  DUT read data; port i at [i*XLEN +: XLEN]
- err_valid  out  1  sticky first-error flag
- err_code  out  2  01 = x0 read nonzero, 10 = data mismatch
- err_port  out  $clog2(RD_PORTS)+1  port index of the first error
- err_reg  out  AW  register address of the first error
- err_expected  out  XLEN  model value at the first error
- err_actual  out  XLEN  DUT value at the first error
- err_count  out  CNT_W  mismatching port-checks
- chk_count  out  CNT_W  port-checks performed
- state  out  2  00 IDLE, 01 CHECKING, 10 FAULT

Function
REQ-005 The block SHALL hold a shadow array of DEPTH x XLEN, updated on each clk edge when wr_en=1 and wr_reg!=0; writes to register 0 SHALL be ignored without raising an error.
REQ-006 The shadow SHALL track writes in every state, including IDLE.
REQ-007 Expected value for port i SHALL be: 0 if rd_reg_i==0; else wr_data if BYPASS=1, wr_en=1 and wr_reg==rd_reg_i; else shadow[rd_reg_i], taken as the pre-edge content.
REQ-008 In CHECKING or FAULT, every port SHALL be compared with === at each edge; a mismatch with rd_reg_i==0 SHALL be code 01, any other mismatch code 10.
REQ-009 Results SHALL be registered: an error sampled at edge N SHALL be visible on the outputs after edge N, i.e. one-cycle latency.
REQ-010 chk_count SHALL add RD_PORTS per checking edge; err_count SHALL add the number of mismatching ports; both SHALL saturate at all-ones.
REQ-011 Capture fields SHALL load only when err_valid=0; with multiple simultaneous mismatches, the lowest port index SHALL win; captured fields SHALL hold until cleared.
REQ-012 State machine SHALL follow these transitions:
- IDLE->CHECKING when chk_en=1
- CHECKING->FAULT on any mismatch
- CHECKING or FAULT->IDLE when chk_en=0, with captures retained
- FAULT->CHECKING on err_clr=1 with no new mismatch
REQ-013 err_clr SHALL zero err_valid, the capture fields and both counters; if a mismatch occurs in the same cycle, the new error SHALL be captured after the clear, so err_count = number of mismatches this cycle and state = FAULT.
REQ-014 In IDLE, no comparisons SHALL occur and the counters SHALL hold.

Reset
REQ-015 When rst_n=0 at an edge, the block SHALL zero the shadow, all outputs and counters, and set state to IDLE; wr_en during reset SHALL be ignored.
REQ-016 Reset asserted mid-operation SHALL take priority over err_clr, writes and checks in the same cycle.

Verification
REQ-017 Write 0xDEADBEEF to x5, then read x5 on port 0 with correct data -> err_valid=0, chk_count=2 per check cycle.
REQ-018 DUT returns 0x1 for rd_reg_1=0 -> next cycle err_valid=1, err_code=01, err_port=1, err_reg=0, state=FAULT.
REQ-019 Write 0x1234 to x0, read x0 returning 0 -> no error, shadow[0] stays 0.
REQ-020 With BYPASS=1, write x7=0xA5A5A5A5 and read x7 in the same cycle returning the old value 0 -> code 10, expected 0xA5A5A5A5, actual 0; with BYPASS=0, the same stimulus -> no error.
REQ-021 Ports 0 and 1 mismatch in the same cycle together with err_clr=1 -> err_count=2, err_port=0, state=FAULT.
REQ-022 Drive 70000 checking cycles with CNT_W=16 -> chk_count holds at 0xFFFF; assert rst_n=0 mid-run -> all outputs 0 and state IDLE after the edge.

Source files
------------

// File: rtl/rf_shadow_checker.sv
// rf_shadow_checker: keeps a shadow copy of a register file from its write port
// and checks each read port of the DUT register file against it.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   chk_en              enables read checking (IDLE <-> CHECKING/FAULT)
//   err_clr             clears capture fields and counters
//   wr_en/wr_reg/wr_data   DUT write port (shadow tracks it in every state)
//   rd_reg/rd_data      packed read ports, port i at [i*AW +: AW] / [i*XLEN +: XLEN]
//   err_valid           sticky first-error flag
//   err_code            01 = x0 read nonzero, 10 = data mismatch
//   err_port/err_reg/err_expected/err_actual   first-error capture
//   err_count/chk_count saturating mismatch / port-check counters
//   state               00 IDLE, 01 CHECKING, 10 FAULT

// Per-port expected value and compare.
module rf_shadow_lane #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 0
) (
  input  logic [AW-1:0]   rd_reg,
  input  logic [XLEN-1:0] rd_data,
  input  logic [XLEN-1:0] shadow_val,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_reg,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] expected,
  output logic            mismatch
);
  always_comb begin
    if (rd_reg == '0)
      expected = '0;
    else if (BYPASS != 0 && wr_en && wr_reg == rd_reg)
      expected = wr_data;
    else
      expected = shadow_val;
    // case inequality: an X/Z on the DUT read data counts as a mismatch
    mismatch = (rd_data !== expected);
  end
endmodule

module rf_shadow_checker #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int RD_PORTS = 2,
  parameter int BYPASS   = 0,
  parameter int CNT_W    = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = $clog2(RD_PORTS) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     chk_en,
  input  logic                     err_clr,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_reg,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [RD_PORTS*AW-1:0]   rd_reg,
  input  logic [RD_PORTS*XLEN-1:0] rd_data,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [PW-1:0]            err_port,
  output logic [AW-1:0]            err_reg,
  output logic [XLEN-1:0]          err_expected,
  output logic [XLEN-1:0]          err_actual,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         chk_count,
  output logic [1:0]               state
);
  typedef enum logic [1:0] {IDLE = 2'b00, CHECKING = 2'b01, FAULT = 2'b10} state_e;

  state_e                             state_q, state_d;
  logic [DEPTH-1:0][XLEN-1:0]         shadow;
  logic [RD_PORTS-1:0][AW-1:0]        rd_reg_a;
  logic [RD_PORTS-1:0][XLEN-1:0]      rd_data_a, exp_a;
  logic [RD_PORTS-1:0]                mis;

  assign rd_reg_a  = rd_reg;
  assign rd_data_a = rd_data;
  assign state     = state_q;

  for (genvar g = 0; g < RD_PORTS; g++) begin : g_lane
    rf_shadow_lane #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_lane (
      .rd_reg     (rd_reg_a[g]),
      .rd_data    (rd_data_a[g]),
      .shadow_val (shadow[rd_reg_a[g]]),
      .wr_en      (wr_en),
      .wr_reg     (wr_reg),
      .wr_data    (wr_data),
      .expected   (exp_a[g]),
      .mismatch   (mis[g])
    );
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W:0]   b);
    logic [CNT_W+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s[CNT_W+1:CNT_W] != 2'b00) ? '1 : s[CNT_W-1:0];
  endfunction

  logic                checking;
  logic [CNT_W:0]      n_mis;
  logic                nx_valid;
  logic [1:0]          nx_code;
  logic [PW-1:0]       nx_port;
  logic [AW-1:0]       nx_reg;
  logic [XLEN-1:0]     nx_exp, nx_act;
  logic [CNT_W-1:0]    nx_err, nx_chk;
  logic [PW-1:0]       f_port;

  assign checking = (state_q != IDLE);

  always_comb begin
    n_mis  = '0;
    f_port = '0;
    // descending scan so the lowest mismatching port is the one left standing
    for (int i = RD_PORTS - 1; i >= 0; i--) begin
      n_mis = n_mis + (CNT_W+1)'(mis[i]);
      if (mis[i]) f_port = PW'(i);
    end

    // clear first, then fold in this cycle's results on top of the cleared values
    nx_valid = err_clr ? 1'b0 : err_valid;
    nx_code  = err_clr ? '0   : err_code;
    nx_port  = err_clr ? '0   : err_port;
    nx_reg   = err_clr ? '0   : err_reg;
    nx_exp   = err_clr ? '0   : err_expected;
    nx_act   = err_clr ? '0   : err_actual;
    nx_err   = err_clr ? '0   : err_count;
    nx_chk   = err_clr ? '0   : chk_count;

    if (checking) begin
      nx_chk = sat_add(nx_chk, (CNT_W+1)'(RD_PORTS));
      nx_err = sat_add(nx_err, n_mis);
      if (!nx_valid && |mis) begin
        nx_valid = 1'b1;
        nx_port  = f_port;
        nx_reg   = rd_reg_a[f_port];
        nx_exp   = exp_a[f_port];
        nx_act   = rd_data_a[f_port];
        nx_code  = (rd_reg_a[f_port] == '0) ? 2'b01 : 2'b10;
      end
    end

    state_d = state_q;
    case (state_q)
      IDLE:     if (chk_en) state_d = CHECKING;
      CHECKING: if (!chk_en) state_d = IDLE;
                else if (|mis) state_d = FAULT;
      FAULT:    if (!chk_en) state_d = IDLE;
                else if (err_clr && !(|mis)) state_d = CHECKING;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow       <= '0;
      state_q      <= IDLE;
      err_valid    <= 1'b0;
      err_code     <= '0;
      err_port     <= '0;
      err_reg      <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      err_count    <= '0;
      chk_count    <= '0;
    end else begin
      if (wr_en && wr_reg != '0) shadow[wr_reg] <= wr_data;
      state_q      <= state_d;
      err_valid    <= nx_valid;
      err_code     <= nx_code;
      err_port     <= nx_port;
      err_reg      <= nx_reg;
      err_expected <= nx_exp;
      err_actual   <= nx_act;
      err_count    <= nx_err;
      chk_count    <= nx_chk;
    end
  end
endmodule

// File: tb/tb_rf_shadow_checker.sv
module tb_rf_shadow_checker;
  logic        clk = 1'b0;
  logic        rst_n, chk_en, err_clr, wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;

  logic        ev[2];
  logic [1:0]  ec[2];
  logic [1:0]  ep[2];
  logic [4:0]  er[2];
  logic [31:0] ee[2], ea[2];
  logic [15:0] ecnt[2], ccnt[2];
  logic [1:0]  st[2];

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  // instance 0: BYPASS=0, instance 1: BYPASS=1, same stimulus
  for (genvar k = 0; k < 2; k++) begin : g_dut
    rf_shadow_checker #(.XLEN(32), .DEPTH(32), .RD_PORTS(2), .BYPASS(k), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .err_clr(err_clr),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
      .rd_reg(rd_reg), .rd_data(rd_data),
      .err_valid(ev[k]), .err_code(ec[k]), .err_port(ep[k]), .err_reg(er[k]),
      .err_expected(ee[k]), .err_actual(ea[k]),
      .err_count(ecnt[k]), .chk_count(ccnt[k]), .state(st[k])
    );
  end

  // reference model: register array plus plain-integer bookkeeping
  logic [31:0] m_sh[2][32];
  int          m_st[2];
  bit          m_v[2];
  int          m_code[2], m_port[2], m_reg[2];
  logic [31:0] m_exp[2], m_act[2];
  int          m_err[2], m_chk[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expv(int k, int p);
    int r;
    r = int'(rd_reg[p*5 +: 5]);
    if (r == 0) return 32'h0;
    if (k == 1 && wr_en && int'(wr_reg) == r) return wr_data;
    return m_sh[k][r];
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n, fp, ns;
      logic [31:0] e, a, fe, fa;
      if (!rst_n) begin
        for (int r = 0; r < 32; r++) m_sh[k][r] = 0;
        m_st[k] = 0; m_v[k] = 0; m_code[k] = 0; m_port[k] = 0; m_reg[k] = 0;
        m_exp[k] = 0; m_act[k] = 0; m_err[k] = 0; m_chk[k] = 0;
        continue;
      end
      n = 0; fp = -1; fe = 0; fa = 0;
      if (m_st[k] != 0)
        for (int p = 0; p < 2; p++) begin
          e = expv(k, p);
          a = rd_data[p*32 +: 32];
          if (a !== e) begin
            n++;
            if (fp < 0) begin fp = p; fe = e; fa = a; end
          end
        end
      if (err_clr) begin
        m_v[k] = 0; m_code[k] = 0; m_port[k] = 0; m_reg[k] = 0;
        m_exp[k] = 0; m_act[k] = 0; m_err[k] = 0; m_chk[k] = 0;
      end
      if (m_st[k] != 0) begin
        m_chk[k] = (m_chk[k] + 2 > 65535) ? 65535 : m_chk[k] + 2;
        m_err[k] = (m_err[k] + n > 65535) ? 65535 : m_err[k] + n;
        if (!m_v[k] && n > 0) begin
          m_v[k] = 1; m_port[k] = fp; m_reg[k] = int'(rd_reg[fp*5 +: 5]);
          m_exp[k] = fe; m_act[k] = fa;
          m_code[k] = (m_reg[k] == 0) ? 1 : 2;
        end
      end
      ns = m_st[k];
      if (m_st[k] == 0) ns = chk_en ? 1 : 0;
      else if (!chk_en) ns = 0;
      else if (m_st[k] == 1) ns = (n > 0) ? 2 : 1;
      else ns = (err_clr && n == 0) ? 1 : 2;
      m_st[k] = ns;
    end
    for (int k = 0; k < 2; k++)
      if (rst_n && wr_en && wr_reg != 0) m_sh[k][wr_reg] = wr_data;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.err_valid", k), 64'(ev[k]), 64'(m_v[k]));
      chk($sformatf("d%0d.err_code", k), 64'(ec[k]), 64'(m_code[k]));
      chk($sformatf("d%0d.err_port", k), 64'(ep[k]), 64'(m_port[k]));
      chk($sformatf("d%0d.err_reg", k), 64'(er[k]), 64'(m_reg[k]));
      chk($sformatf("d%0d.err_expected", k), 64'(ee[k]), 64'(m_exp[k]));
      chk($sformatf("d%0d.err_actual", k), 64'(ea[k]), 64'(m_act[k]));
      chk($sformatf("d%0d.err_count", k), 64'(ecnt[k]), 64'(m_err[k]));
      chk($sformatf("d%0d.chk_count", k), 64'(ccnt[k]), 64'(m_chk[k]));
      chk($sformatf("d%0d.state", k), 64'(st[k]), 64'(m_st[k]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic cl, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1);
    rst_n = r; chk_en = c; err_clr = cl; wr_en = we; wr_reg = wr; wr_data = wd;
    rd_reg = {r1, r0}; rd_data = {d1, d0};
  endtask

  initial begin
    drive(0, 0, 0, 1, 5'd3, 32'h55, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) m_st[k] = 0;
    @(negedge clk);
    tick(); tick();
    check_all();
    chk("reset.state", 64'(st[0]), 64'd0);
    chk("reset.chk_count", 64'(ccnt[0]), 64'd0);

    // write x5 then read it back correctly
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);                   tick(); check_all();
    drive(1, 1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);     tick(); check_all();
    drive(1, 1, 0, 0, 0, 0, 5'd5, 0, 32'hDEADBEEF, 0);     tick(); check_all();
    chk("rd_x5.err_valid", 64'(ev[0]), 64'd0);
    chk("rd_x5.chk_count", 64'(ccnt[0]), 64'd4);

    // x0 read returns nonzero on port 1
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1);               tick(); check_all();
    chk("x0.err_valid", 64'(ev[0]), 64'd1);
    chk("x0.err_code", 64'(ec[0]), 64'd1);
    chk("x0.err_port", 64'(ep[0]), 64'd1);
    chk("x0.err_reg", 64'(er[0]), 64'd0);
    chk("x0.state", 64'(st[0]), 64'd2);

    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);                   tick(); check_all();
    chk("clr.state", 64'(st[0]), 64'd1);
    chk("clr.err_count", 64'(ecnt[0]), 64'd0);

    // write to x0 is dropped
    drive(1, 1, 0, 1, 5'd0, 32'h1234, 0, 0, 0, 0);         tick(); check_all();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);                   tick(); check_all();
    chk("wr_x0.err_valid", 64'(ev[0]), 64'd0);

    // same-cycle write/read of x7: only the bypass instance flags it
    drive(1, 1, 0, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 0, 0, 0);  tick(); check_all();
    chk("byp0.err_valid", 64'(ev[0]), 64'd0);
    chk("byp1.err_code", 64'(ec[1]), 64'd2);
    chk("byp1.err_expected", 64'(ee[1]), 64'hA5A5A5A5);
    chk("byp1.err_actual", 64'(ea[1]), 64'd0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);                   tick(); check_all();

    // two ports mismatch while clearing
    drive(1, 1, 1, 0, 0, 0, 5'd5, 5'd5, 0, 0);             tick(); check_all();
    chk("dual.err_count", 64'(ecnt[0]), 64'd2);
    chk("dual.err_port", 64'(ep[0]), 64'd0);
    chk("dual.state", 64'(st[0]), 64'd2);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);                   tick(); check_all();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(199) != 0);
      chk_en  = ($urandom_range(9) != 0);
      err_clr = ($urandom_range(19) == 0);
      wr_en   = $urandom_range(1);
      wr_reg  = 5'($urandom_range(31));
      wr_data = $urandom;
      rd_reg  = 10'($urandom);
      for (int p = 0; p < 2; p++)
        rd_data[p*32 +: 32] = ($urandom_range(99) < 85) ? expv(0, p) : 32'($urandom);
      tick();
      check_all();
    end

    // counter saturation
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);                   tick();
    err_clr = 0;
    for (int i = 0; i < 70000; i++) tick();
    check_all();
    chk("sat.chk_count", 64'(ccnt[0]), 64'hFFFF);

    // reset beats clear, write and a mismatching check in the same cycle
    drive(0, 1, 1, 1, 5'd5, 32'h77, 5'd5, 0, 32'h99, 0);   tick(); check_all();
    chk("rst.state", 64'(st[0]), 64'd0);
    chk("rst.chk_count", 64'(ccnt[0]), 64'd0);
    chk("rst.err_valid", 64'(ev[1]), 64'd0);
    drive(1, 1, 0, 0, 0, 0, 5'd5, 0, 0, 0);                tick(); check_all();
    tick(); check_all();
    chk("post_rst.err_valid", 64'(ev[0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
